chaos_seq_array: RTL and testbench
==================================

CHAOS_SEQ_ARRAY -- requirements
Module: chaos_seq_array

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, meaning the number of independent logistic-map channels.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the state width per channel, unsigned fixed-point Q0.DATA_W.
REQ-003 The block SHALL have parameter ITERATIONS, default 200, meaning the number of warm-up iterations discarded after seeding (0 allowed).
REQ-004 The block SHALL have ports clk  in  1  clock; one clock; all logic is on its rising edge.
REQ-005 The block SHALL have ports rst  in  1  reset; asynchronous, active-high.
REQ-006 The block SHALL have ports mu  in  DATA_W+2  map gain, Q2.DATA_W, sampled at seed accept.
REQ-007 The block SHALL have ports out_len  in  16  samples to emit, sampled at seed accept; 0 = unlimited.
REQ-008 The block SHALL have ports chaos_x0  in  NUM_CH*DATA_W  per-channel seeds; channel k in bits [k*DATA_W +: DATA_W].
REQ-009 The block SHALL have ports chaos_x0_vld  in  1 and chaos_x0_rdy  out  1  seed handshake.
REQ-010 The block SHALL have ports abort  in  1  return to IDLE.
REQ-011 The block SHALL have ports chaos_xout  out  NUM_CH*DATA_W, chaos_xout_vld  out  1, chaos_xout_rdy  in  1  sample stream.
REQ-012 The block SHALL have ports busy  out  1  high in any state other than IDLE.

Function
REQ-013 The map SHALL be x' = (mu_r * floor(x*(2^DATA_W - x) / 2^DATA_W)) >> DATA_W, truncating and using full-width intermediate products; result never exceeds 2^DATA_W-1, so no saturation logic exists.
REQ-014 All channels SHALL iterate in lockstep, one iteration per clock, sharing mu_r.
REQ-015 FSM states SHALL be IDLE, WARMUP, OUTPUT.
REQ-016 IDLE: chaos_x0_rdy=1; on chaos_x0_vld, it SHALL load seeds, mu_r and len_r, clear the iteration counter, and go to WARMUP (ITERATIONS>0) or OUTPUT (ITERATIONS=0).
REQ-017 WARMUP: it SHALL apply one iteration per cycle; after exactly ITERATIONS iterations it SHALL enter OUTPUT, so chaos_xout_vld first rises ITERATIONS+1 cycles after the seed-accept edge.
REQ-018 OUTPUT: chaos_xout_vld=1 and chaos_xout SHALL equal the current state, held stable while chaos_xout_rdy=0.
REQ-019 On a vld&rdy transfer, the state SHALL advance one iteration; if len_r≠0, len_r decrements, and the transfer making it 0 SHALL return to IDLE.
REQ-020 abort SHALL force IDLE on the next edge from any state, dropping chaos_xout_vld without a transfer; abort SHALL have priority over a simultaneous transfer or seed accept.
REQ-021 chaos_x0_rdy SHALL be 0 outside IDLE; seeds offered then SHALL be ignored.

Reset
REQ-022 rst SHALL asynchronously force IDLE, with all channel states, mu_r, len_r and the counter at 0.
REQ-023 During reset, chaos_xout_vld=0, chaos_xout=0, busy=0 and chaos_x0_rdy=0; chaos_x0_rdy SHALL rise on the first edge after rst deasserts.
REQ-024 Reset mid-WARMUP or mid-OUTPUT SHALL discard all progress, with no output transfer completed.

Configuration
REQ-025 With CHAOS_ZERO_GUARD_EN defined, any channel whose computed next state is 0 SHALL load that channel's latched seed instead, and a seed of 0 SHALL be latched as 1.
REQ-026 Without CHAOS_ZERO_GUARD_EN, zero states SHALL propagate unchanged and seed registers SHALL not be retained after load.

Verification
REQ-027 Scenario: DATA_W=16, ITERATIONS=0, mu=0x30000, x0=0x8000 on all channels -> outputs 0x8000, 0xC000, 0x9000 in order.
REQ-028 Scenario: ITERATIONS=2, same mu/x0, out_len=1 -> single sample 0x9000, vld first at seed-accept+3, then IDLE with busy=0.
REQ-029 Scenario: chaos_xout_rdy held 0 for 10 cycles in OUTPUT -> chaos_xout stable and vld high throughout; no state advance.
REQ-030 Scenario: mu=0, x0=0x8000 -> with the macro the second sample is 0x8000; without it the second sample is 0x0000.
REQ-031 Scenario: abort asserted simultaneously with vld&rdy -> no advance, IDLE next cycle; rst pulsed mid-WARMUP -> all outputs 0 immediately.
REQ-032 Scenario: NUM_CH=4 with distinct seeds and ITERATIONS=5 -> each channel matches an independent reference model bit-exactly.

Source files
------------

// File: rtl/chaos_seq_array.sv
// Multi-channel logistic-map sequencer: seed, warm up, then stream samples.
// Optional CHAOS_ZERO_GUARD_EN reloads a channel's latched seed on a zero state.
module chaos_seq_array #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 32,
  parameter int ITERATIONS = 200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W+1:0]        mu,
  input  logic [15:0]              out_len,
  input  logic [NUM_CH*DATA_W-1:0] chaos_x0,
  input  logic                     chaos_x0_vld,
  output logic                     chaos_x0_rdy,
  input  logic                     abort,
  output logic [NUM_CH*DATA_W-1:0] chaos_xout,
  output logic                     chaos_xout_vld,
  input  logic                     chaos_xout_rdy,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_OUTPUT
  } state_t;

  localparam int CNT_W =
    (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [CNT_W-1:0] LAST_IT =
    CNT_W'((ITERATIONS > 0) ? ITERATIONS - 1 : 0);

  state_t                              r_state;
  logic [DATA_W+1:0]                   r_mu;
  logic [15:0]                         r_len;
  logic [CNT_W-1:0]                    r_cnt;
  logic                                r_rdy;
  logic                                r_vld;
  logic                                r_busy;
  logic [NUM_CH-1:0][DATA_W-1:0]       r_x;
  logic [NUM_CH-1:0][DATA_W-1:0]       w_nxt;
  logic [NUM_CH-1:0][DATA_W-1:0]       w_seed;
`ifdef CHAOS_ZERO_GUARD_EN
  logic [NUM_CH-1:0][DATA_W-1:0]       r_seed;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DATA_W:0]     w_cmp;
    logic [2*DATA_W:0]   w_p1;
    logic [DATA_W-1:0]   w_q;
    logic [2*DATA_W+1:0] w_p2;
    logic [DATA_W-1:0]   w_n;
    logic [DATA_W-1:0]   w_in;

    assign w_in  = chaos_x0[k*DATA_W +: DATA_W];
    assign w_cmp = {1'b1, {DATA_W{1'b0}}}
                 - {1'b0, r_x[k]};
    assign w_p1  = (2*DATA_W+1)'(r_x[k])
                 * (2*DATA_W+1)'(w_cmp);
    assign w_q   = DATA_W'(w_p1 >> DATA_W);
    // mu < 4.0 and w_q <= 2^(DATA_W-2): result fits DATA_W
    assign w_p2  = (2*DATA_W+2)'(r_mu)
                 * (2*DATA_W+2)'(w_q);
    assign w_n   = DATA_W'(w_p2 >> DATA_W);
`ifdef CHAOS_ZERO_GUARD_EN
    assign w_seed[k] = (w_in == '0) ? DATA_W'(1) : w_in;
    assign w_nxt[k]  = (w_n == '0) ? r_seed[k] : w_n;
`else
    assign w_seed[k] = w_in;
    assign w_nxt[k]  = w_n;
`endif
    assign chaos_xout[k*DATA_W +: DATA_W] = r_x[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mu    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_rdy   <= 1'b0;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_x     <= '0;
`ifdef CHAOS_ZERO_GUARD_EN
      r_seed  <= '0;
`endif
    end else if (abort) begin
      r_state <= S_IDLE;
      r_rdy   <= 1'b1;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_rdy <= 1'b1;
          if (r_rdy && chaos_x0_vld) begin
            r_x    <= w_seed;
            r_mu   <= mu;
            r_len  <= out_len;
            r_cnt  <= '0;
            r_rdy  <= 1'b0;
            r_busy <= 1'b1;
`ifdef CHAOS_ZERO_GUARD_EN
            r_seed <= w_seed;
`endif
            if (ITERATIONS == 0) begin
              r_state <= S_OUTPUT;
              r_vld   <= 1'b1;
            end else begin
              r_state <= S_WARMUP;
            end
          end
        end
        S_WARMUP: begin
          r_x   <= w_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_IT) begin
            r_state <= S_OUTPUT;
            r_vld   <= 1'b1;
          end
        end
        S_OUTPUT: begin
          if (chaos_xout_rdy) begin
            r_x <= w_nxt;
            if (r_len != 16'd0) begin
              r_len <= r_len - 16'd1;
              if (r_len == 16'd1) begin
                r_state <= S_IDLE;
                r_vld   <= 1'b0;
                r_busy  <= 1'b0;
                r_rdy   <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_vld   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign chaos_x0_rdy   = r_rdy;
  assign chaos_xout_vld = r_vld;
  assign busy           = r_busy;

endmodule

// File: tb/tb_chaos_seq_array.sv
// Scoreboard bench for chaos_seq_array: three 4-channel 16-bit instances
// with 0, 2 and 5 warm-up iterations.
module tb_chaos_seq_array;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [W+1:0]   mu = '0;
  logic [15:0]    out_len = '0;
  logic [N*W-1:0] x0 = '0;
  logic [2:0]     x0_vld = '0;
  logic [2:0]     x0_rdy;
  logic [2:0]     abort = '0;
  logic [2:0]     xrdy = '0;
  logic [2:0]     xvld;
  logic [2:0]     busy;
  logic [N*W-1:0] xout [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    chaos_seq_array #(
      .NUM_CH(N),
      .DATA_W(W),
      .ITERATIONS((g == 0) ? 0 : ((g == 1) ? 2 : 5))
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .mu(mu),
      .out_len(out_len),
      .chaos_x0(x0),
      .chaos_x0_vld(x0_vld[g]),
      .chaos_x0_rdy(x0_rdy[g]),
      .abort(abort[g]),
      .chaos_xout(xout[g]),
      .chaos_xout_vld(xvld[g]),
      .chaos_xout_rdy(xrdy[g]),
      .busy(busy[g])
    );
  end

  int n_chk = 0;
  int n_pass = 0;
  int sel = 0;
  logic [N*W-1:0] exp_q [$];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic int its_of(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 2 : 5);
  endfunction

  function automatic logic [N*W-1:0] grd(input logic [N*W-1:0] s);
    logic [N*W-1:0] r;
    r = s;
`ifdef CHAOS_ZERO_GUARD_EN
    for (int k = 0; k < N; k++)
      if (s[k*W +: W] == '0) r[k*W +: W] = 16'd1;
`endif
    return r;
  endfunction

  function automatic logic [N*W-1:0] step_all(
    input logic [N*W-1:0] x,
    input logic [W+1:0]   m,
    input logic [N*W-1:0] s);
    logic [N*W-1:0] r;
    longint xi, q, n;
    logic [W-1:0] nv;
    for (int k = 0; k < N; k++) begin
      xi = longint'(x[k*W +: W]);
      q  = (xi * (65536 - xi)) / 65536;
      n  = (longint'(m) * q) / 65536;
      nv = n[15:0];
`ifdef CHAOS_ZERO_GUARD_EN
      if (nv == '0) nv = s[k*W +: W];
`endif
      r[k*W +: W] = nv;
    end
    return r;
  endfunction

  // Caller is aligned to posedge+2; returns aligned just after accept edge.
  task automatic seed(input int g, input logic [W+1:0] m,
                      input logic [15:0] len,
                      input logic [N*W-1:0] sd, input int npush);
    int t;
    int n;
    logic [N*W-1:0] s, x;
    t = 0;
    while (!x0_rdy[g] && t < 20) begin
      @(posedge clk); #2;
      t++;
    end
    check("seed_rdy", 64'(x0_rdy[g]), 64'd1);
    sel = g;
    mu = m;
    out_len = len;
    x0 = sd;
    x0_vld[g] = 1'b1;
    s = grd(sd);
    x = s;
    for (int i = 0; i < its_of(g); i++) x = step_all(x, m, s);
    n = (len == 0) ? npush : int'(len);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(x);
      x = step_all(x, m, s);
    end
    @(posedge clk); #2;
    x0_vld[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g, input bit rnd,
                           input int budget);
    int t;
    t = 0;
    while ((busy[g] || exp_q.size() != 0) && t < budget) begin
      @(posedge clk); #2;
      if (rnd) xrdy[g] = 1'($urandom_range(0, 1));
      t++;
    end
    check("idle_timeout", 64'(t < budget), 64'd1);
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && xvld[sel] && xrdy[sel] && !abort[sel]) begin
      if (exp_q.size() == 0)
        check("sb_extra", 64'(exp_q.size()), 64'd1);
      else
        check("sample", xout[sel], exp_q.pop_front());
    end
  end

  initial begin : main
    int k;
    logic [N*W-1:0] sd;
    logic [W+1:0] m;
    #1 rst = 1'b1;
    #2;
    for (int g = 0; g < 3; g++) begin
      check("rst_vld", 64'(xvld[g]), 64'd0);
      check("rst_out", xout[g], 64'd0);
      check("rst_busy", 64'(busy[g]), 64'd0);
      check("rst_rdy", 64'(x0_rdy[g]), 64'd0);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    check("rdy_pre_edge", 64'(x0_rdy[0]), 64'd0);
    @(posedge clk); #2;
    check("rdy_post_edge", 64'(x0_rdy[0]), 64'd1);

    // basic sequence, no warm-up
    xrdy[0] = 1'b1;
    seed(0, 18'h30000, 16'd3, {4{16'h8000}}, 0);
    wait_idle(0, 1'b0, 50);

    // two warm-up iterations, single sample, latency
    xrdy[1] = 1'b1;
    seed(1, 18'h30000, 16'd1, {4{16'h8000}}, 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!xvld[1] && k < 20);
    check("vld_latency", 64'(k), 64'd3);
    check("vld_data", xout[1], {4{16'h9000}});
    @(posedge clk); #2;
    check("busy_done", 64'(busy[1]), 64'd0);
    check("vld_done", 64'(xvld[1]), 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    // stall, ignored seed, then abort racing a transfer
    xrdy[0] = 1'b0;
    seed(0, 18'h30000, 16'd0, {4{16'h8000}}, 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_out", xout[0], {4{16'h8000}});
      check("stall_vld", 64'(xvld[0]), 64'd1);
      if (i == 3) begin
        x0 = {4{16'h1111}};
        x0_vld[0] = 1'b1;
      end
      if (i == 5) begin
        check("rdy_busy", 64'(x0_rdy[0]), 64'd0);
        x0_vld[0] = 1'b0;
      end
    end
    @(posedge clk); #2 xrdy[0] = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2 abort[0] = 1'b1;
    @(posedge clk); #2;
    abort[0] = 1'b0;
    xrdy[0] = 1'b0;
    check("abort_vld", 64'(xvld[0]), 64'd0);
    check("abort_busy", 64'(busy[0]), 64'd0);
    check("abort_rdy", 64'(x0_rdy[0]), 64'd1);
    check("abort_hold", xout[0], {4{16'h9000}});
    check("abort_left", 64'(exp_q.size()), 64'd1);
    exp_q.delete();

    // zero gain: guard behaviour on the second sample
    xrdy[0] = 1'b1;
    seed(0, 18'h00000, 16'd2, {4{16'h8000}}, 0);
    wait_idle(0, 1'b0, 50);

    // reset mid-warm-up
    seed(2, 18'h3F000, 16'd4, {4{16'h4321}}, 0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out", xout[2], 64'd0);
    check("mid_rst_vld", 64'(xvld[2]), 64'd0);
    check("mid_rst_busy", 64'(busy[2]), 64'd0);
    check("mid_rst_rdy", 64'(x0_rdy[2]), 64'd0);
    exp_q.delete();
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #2;

    // distinct seeds, five warm-up iterations
    xrdy[2] = 1'b1;
    seed(2, 18'h3F000, 16'd6,
         {16'h0001, 16'hFFFF, 16'h8000, 16'h1234}, 0);
    wait_idle(2, 1'b0, 100);

    // random gains, seeds, lengths and back-pressure
    for (int r = 0; r < 6; r++) begin
      m = 18'($urandom_range(0, 18'h3FFFF));
      sd = {$urandom, $urandom};
      xrdy[r % 3] = 1'b1;
      seed(r % 3, m, 16'($urandom_range(1, 8)), sd, 0);
      wait_idle(r % 3, 1'b1, 300);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
